// File: rtl/main_control_fsm.sv
// Multicycle main control unit for the RV32I datapath: latches each fetched
// instruction into the IR and steps it through FETCH/DECODE/EXEC/MEM/WB.
module main_control_fsm #(
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  input  logic                   mem_ready,
  output logic [INSTR_WIDTH-1:0] ir_out,
  output logic [1:0]             ALUOp,
  output logic                   Branch,
  output logic                   Jump,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   ALUSrc,
  output logic                   RegWrite,
  output logic                   IRWrite,
  output logic                   instr_done,
  output logic                   illegal_instr,
  output logic [2:0]             state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RFUNC = 2'b10;
  localparam logic [1:0] ALU_IFUNC = 2'b11;

  typedef enum logic [3:0] {
    CLS_R, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } iclass_t;

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic [INSTR_WIDTH-1:0] ir_q;
  iclass_t                iclass;
  logic                   rd_nonzero;

  assign ir_out     = ir_q;
  assign state      = state_q;
  assign rd_nonzero = |ir_q[11:7];

  // Classification depends only on the latched IR, so it is stable for the
  // whole life of the instruction.
  always_comb begin
    iclass = CLS_ILLEGAL;
    case (ir_q[6:0])
      OP_R:      iclass = CLS_R;
      OP_IMM:    iclass = CLS_OPIMM;
      OP_LOAD:   iclass = CLS_LOAD;
      OP_STORE:  iclass = CLS_STORE;
      OP_BRANCH: iclass = CLS_BRANCH;
      OP_JAL:    iclass = CLS_JAL;
      OP_JALR:   iclass = CLS_JALR;
      OP_LUI:    iclass = CLS_LUI;
      OP_AUIPC:  iclass = CLS_AUIPC;
      default:   iclass = CLS_ILLEGAL;
    endcase
  end

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (instr_valid) state_d = DECODE;
      DECODE: state_d = (iclass == CLS_ILLEGAL) ? TRAP : EXEC;
      EXEC: begin
        if (iclass == CLS_BRANCH)
          state_d = FETCH;
        else if (iclass == CLS_LOAD || iclass == CLS_STORE)
          state_d = MEM;
        else
          state_d = WB;
      end
      MEM: if (mem_ready) state_d = (iclass == CLS_LOAD) ? WB : FETCH;
      WB:      state_d = FETCH;
      TRAP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: reset is synchronous and active-low, sampled only on the clock edge; sequential state uses <= exclusively.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && instr_valid) ir_q <= instr;
    end
  end

  always_comb begin
    ALUOp         = ALU_ADD;
    Branch        = 1'b0;
    Jump          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrc        = 1'b0;
    RegWrite      = 1'b0;
    IRWrite       = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      FETCH: IRWrite = instr_valid;
      EXEC: begin
        case (iclass)
          CLS_R: begin
            ALUOp = ALU_RFUNC;
          end
          CLS_OPIMM: begin
            ALUOp  = ALU_IFUNC;
            ALUSrc = 1'b1;
          end
          CLS_BRANCH: begin
            ALUOp      = ALU_SUB;
            Branch     = 1'b1;
            instr_done = 1'b1;
          end
          CLS_JAL, CLS_JALR: begin
            ALUSrc = 1'b1;
            Jump   = 1'b1;
          end
          default: ALUSrc = 1'b1;
        endcase
      end
      MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (iclass == CLS_LOAD);
        MemWrite = (iclass == CLS_STORE);
        // A store retires in the cycle its write completes, so this pulse
        // alone follows mem_ready in the same cycle.
        instr_done = (iclass == CLS_STORE) && mem_ready;
      end
      WB: begin
        RegWrite   = rd_nonzero;
        MemtoReg   = (iclass == CLS_LOAD);
        instr_done = 1'b1;
      end
      TRAP: illegal_instr = 1'b1;
      default: ;
    endcase
  end

endmodule
